// File: rtl/mmc_call_pkg.sv
// Shared types and helpers for the mmc call driver.
package mmc_call_pkg;

    localparam int unsigned DW_DEFAULT = 32;

    typedef enum logic {
        ST_IDLE,
        ST_CALL
    } call_state_e;

    // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mmc_call_res_fifo.sv
// First-word-fall-through result FIFO; head entry and empty flag come straight from registers.
module mmc_call_res_fifo
    import mmc_call_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        push,
    input  logic [DW-1:0]               din,
    input  logic                        pop,
    output logic [DW-1:0]               dout,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rd_ptr];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mmc_call_driver.sv
// Caller-side initiator for the mmc call/return interface with credit-based issue.
// Optional watchdog: define MMC_CALL_DRIVER_TIMEOUT_EN.
module mmc_call_driver
    import mmc_call_pkg::*;
#(
    parameter int unsigned DW        = DW_DEFAULT,
    parameter int unsigned RES_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    output logic          mmc_start,
    input  logic          mmc_busy,
    output logic [DW-1:0] mmc_a,
    output logic [DW-1:0] mmc_b,
    input  logic          mmc_done,
    output logic          mmc_stall,
    input  logic [DW-1:0] mmc_returndata,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          idle,
    output logic          timeout_err
);

    localparam int unsigned CW = cnt_width(RES_DEPTH);
    localparam int unsigned UW = CW + 1;

    call_state_e   state;
    call_state_e   state_nxt;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [UW-1:0] used;
    logic          credit;
    logic          cmd_take;
    logic          call_acc;
    logic          ret_take;
    logic          fifo_full;
    logic          fifo_empty;

    // A registered-but-unaccepted call already owns a result slot.
    always_comb begin
        used     = UW'(inflight) + UW'(fifo_count) + UW'(state == ST_CALL);
        credit   = (used < UW'(RES_DEPTH));
        call_acc = mmc_start && !mmc_busy;
        ret_take = mmc_done && !mmc_stall && (inflight != '0);
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        mmc_start = 1'b0;
        cmd_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = resetn && credit;
                cmd_take  = cmd_valid && cmd_ready;
                if (cmd_take) state_nxt = ST_CALL;
            end
            ST_CALL: begin
                mmc_start = 1'b1;
                if (!mmc_busy) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            mmc_a    <= '0;
            mmc_b    <= '0;
            inflight <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_take) begin
                mmc_a <= cmd_a;
                mmc_b <= cmd_b;
            end
            inflight <= inflight + CW'(call_acc) - CW'(ret_take);
        end
    end

    mmc_call_res_fifo #(
        .DW    (DW),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (ret_take),
        .din    (mmc_returndata),
        .pop    (res_valid && res_ready),
        .dout   (res_data),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        mmc_stall = fifo_full;
        res_valid = !fifo_empty;
        idle      = (state == ST_IDLE) && (inflight == '0) && fifo_empty;
    end

`ifdef MMC_CALL_DRIVER_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        wd_err;

    // Counter saturates at TIMEOUT; the flag is set on the edge the count reaches it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else if (call_acc || ret_take) begin
            wd_cnt <= '0;
        end else if (((inflight != '0) || (state == ST_CALL)) && (wd_cnt != 32'(TIMEOUT))) begin
            wd_cnt <= wd_cnt + 32'd1;
            if (wd_cnt == 32'(TIMEOUT - 1)) wd_err <= 1'b1;
        end
    end

    assign timeout_err = wd_err;
`else
    assign timeout_err = 1'b0;
`endif

`ifndef SYNTHESIS
    done_without_call: assert property (@(posedge clock) disable iff (!resetn)
        !(mmc_done && (inflight == '0)))
        else $error("mmc_done asserted with no call in flight");

    config_sane: assert property (@(posedge clock)
        (RES_DEPTH >= 2) && ((RES_DEPTH & (RES_DEPTH - 1)) == 0) && (TIMEOUT != 0))
        else $error("bad mmc_call_driver configuration");
`endif

endmodule

// File: doc/mmc_call_driver.md
Name: mmc_call_driver

Overview:
- Caller-side initiator for the `mmc` HLS component's call/return interface.
- Accepts argument pairs on a valid/ready command stream and drives `mmc` call signals: start, a, b, honouring busy.
- Collects return valid/data into a result FIFO, and drives return stall from FIFO occupancy.
- Uses credit-based issue so a pipelined `mmc` can have several calls in flight without losing results.

Parameters:
- DW, 32: width of a, b and returndata.
- RES_DEPTH, 4: result FIFO entries; power of two, ≥2; also the maximum number of calls in flight.
- TIMEOUT, 1024: watchdog limit in cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  argument pair valid
- cmd_ready  out  1  driver can take an argument pair
- cmd_a  in  DW  first argument
- cmd_b  in  DW  second argument
- mmc_start  out  1  to `mmc` call.valid
- mmc_busy  in  1  from `mmc` call.stall
- mmc_a  out  DW  to `mmc` a
- mmc_b  out  DW  to `mmc` b
- mmc_done  in  1  from `mmc` return.valid
- mmc_stall  out  1  to `mmc` return.stall
- mmc_returndata  in  DW  from `mmc` returndata
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  DW  result value
- idle  out  1  nothing pending, in flight or buffered
- timeout_err  out  1  sticky watchdog flag (tied 0 when the feature is absent)

Behaviour:
- Clock and reset:
  - One clock: clock.
  - Reset is asynchronous, active-low (resetn), and clears all state immediately.
  - Reset values: cmd_ready=0 only while resetn=0, then follows its rule; mmc_start=0; mmc_a=mmc_b=0; mmc_stall=0; res_valid=0; res_data=0; idle=1; timeout_err=0.
- Call FSM, two states:
  - IDLE: cmd_ready=1 iff credit available. Credit means inflight + fifo_count + (call pending) < RES_DEPTH. On cmd_valid&&cmd_ready, register cmd_a/cmd_b into mmc_a/mmc_b and go to CALL next cycle.
  - CALL: mmc_start=1; mmc_a/mmc_b held stable; cmd_ready=0. A call is accepted on a cycle with mmc_start&&!mmc_busy; that cycle increments inflight and returns to IDLE. mmc_start deasserts the following cycle.
- Issue rate: at most one call every 2 cycles (one registered stage). The busy-gated hold in CALL may last any number of cycles.
- Return path:
  - A result is taken on a cycle with mmc_done&&!mmc_stall. That cycle pushes mmc_returndata into the FIFO and decrements inflight.
  - mmc_stall = (fifo_count == RES_DEPTH). With credits this never asserts in normal operation, but it must be correct.
  - Acceptance and return in the same cycle: inflight is unchanged.
- Result FIFO:
  - First-word-fall-through: res_valid = !empty and res_data = head entry, both registered.
  - Pop on res_valid&&res_ready.
  - Push and pop in the same cycle when full: pop frees the slot, push is still blocked because mmc_stall is already asserted that cycle.
  - Push and pop in the same cycle when empty: the push lands and res_valid rises next cycle, with no bypass.
  - Pointers wrap modulo RES_DEPTH; the count register is clog2(RES_DEPTH)+1 bits.
- Ordering: results are presented in issue order; `mmc` returns in order.
- idle = FSM in IDLE && inflight==0 && fifo empty.
- Protocol errors: mmc_done while inflight==0 is a protocol error. The result is ignored (not pushed), inflight is not decremented, and a simulation-only assertion fires.

Optional Feature:
- Macro MMC_CALL_DRIVER_TIMEOUT_EN.
- When defined:
  - A 32-bit watchdog counts cycles while inflight>0 or the FSM is in CALL.
  - It resets to 0 on every call acceptance or return.
  - On reaching TIMEOUT it sets timeout_err, which is sticky until reset.
  - Timing out does not change the datapath.
- When undefined: no counter is built and timeout_err is tied 0.

Decomposition:
- Package mmc_call_pkg holds:
  - DW_DEFAULT constant;
  - FSM state enum {ST_IDLE, ST_CALL};
  - a function computing the counter width from RES_DEPTH.
- One sub-module, mmc_call_res_fifo: parameterised FWFT FIFO with push, pop, full, empty and count.
- Credit logic, FSM and watchdog stay in the top.

Test Plan:
- Single call:
  - Stimulus: cmd (4, 6) with a bench `mmc` model returning lcm after 5 cycles, busy=0.
  - Required: mmc_start high for exactly 1 cycle with a=4, b=6; res_data=12 with res_valid; idle returns to 1.
- Busy hold:
  - Stimulus: mmc_busy held 1 for 7 cycles during CALL.
  - Required: mmc_start and a/b stable for all 7 cycles, call accepted in cycle 8; cmd_ready=0 throughout.
- Credit exhaustion:
  - Stimulus: RES_DEPTH=4, res_ready=0, 6 commands, model latency 3.
  - Required: exactly 4 calls issued; cmd_ready stays 0; FIFO full; mmc_stall never seen high while mmc_done is high with no space.
  - Then res_ready=1: all 6 results come out in order (lcm values e.g. 12, 15, 42, 8, 30, 9).
- Simultaneous events:
  - Stimulus: return and call acceptance in the same cycle, plus push and pop in the same cycle.
  - Required: inflight and fifo_count unchanged; no result lost or duplicated.
- Reset mid-operation:
  - Stimulus: resetn low while 2 calls are in flight and 1 result is buffered.
  - Required: all outputs at reset values immediately (asynchronous); idle=1 after release.
- Watchdog (with MMC_CALL_DRIVER_TIMEOUT_EN, TIMEOUT=16):
  - Stimulus: model never asserts done.
  - Required: timeout_err rises exactly 16 cycles after call acceptance and stays high until reset.
